octant_pixel_writer: RTL and testbench

OCTANT_PIXEL_WRITER -- requirements
Module: octant_pixel_writer

---
 rtl/octant_pixel_writer_pkg.sv | 18 +
 rtl/octant_pixel_writer_addr.sv | 28 ++
 rtl/octant_pixel_writer.sv | 113 +++++++++++
 tb/tb_octant_pixel_writer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/octant_pixel_writer_pkg.sv
// Shared constants and state encoding for the octant pixel writer.
package octant_pixel_writer_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int FB_ADDR_W = 19;
  localparam int COLOR_W   = 12;
  localparam int COORD_W   = 10;
  localparam int NPTS      = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/octant_pixel_writer_addr.sv
// Linear framebuffer address and clip test for one point.
module pixel_addr_calc
  import octant_pixel_writer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic [COORD_W-1:0]   x_i,
  input  logic [COORD_W-1:0]   y_i,
  output logic [FB_ADDR_W-1:0] addr_o,
  output logic                 in_bounds_o
);

  logic [FB_ADDR_W-1:0] x_ext, y_ext;

  assign x_ext = FB_ADDR_W'(x_i);
  assign y_ext = FB_ADDR_W'(y_i);

  // 640 = 512 + 128, so the default resolution needs only two shifts and adds
  if (H_RES == 640) begin : g_shift
    assign addr_o = (y_ext << 9) + (y_ext << 7) + x_ext;
  end else begin : g_mul
    assign addr_o = y_ext * FB_ADDR_W'(H_RES) + x_ext;
  end

  assign in_bounds_o = (32'(x_i) < H_RES) && (32'(y_i) < V_RES);

endmodule

// File: rtl/octant_pixel_writer.sv
// Walks an 8-point group, dropping clipped and repeated points, one point per cycle.
module octant_pixel_writer
  import octant_pixel_writer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 in_rts,
  output logic                 in_rtr,
  input  logic [COORD_W-1:0]   draw_x_0,
  input  logic [COORD_W-1:0]   draw_x_1,
  input  logic [COORD_W-1:0]   draw_x_2,
  input  logic [COORD_W-1:0]   draw_x_3,
  input  logic [COORD_W-1:0]   draw_x_4,
  input  logic [COORD_W-1:0]   draw_x_5,
  input  logic [COORD_W-1:0]   draw_x_6,
  input  logic [COORD_W-1:0]   draw_x_7,
  input  logic [COORD_W-1:0]   draw_y_0,
  input  logic [COORD_W-1:0]   draw_y_1,
  input  logic [COORD_W-1:0]   draw_y_2,
  input  logic [COORD_W-1:0]   draw_y_3,
  input  logic [COORD_W-1:0]   draw_y_4,
  input  logic [COORD_W-1:0]   draw_y_5,
  input  logic [COORD_W-1:0]   draw_y_6,
  input  logic [COORD_W-1:0]   draw_y_7,
  input  logic [COLOR_W-1:0]   color,
  output logic                 fb_wr_en,
  input  logic                 fb_rtr,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  output logic [15:0]          pix_count,
  output logic [15:0]          clip_count
);

  state_e                          state_q;
  logic [NPTS-1:0][COORD_W-1:0]    x_q, y_q;
  logic [COLOR_W-1:0]              color_q;
  logic [IDX_W-1:0]                idx_q;
  logic [15:0]                     pix_cnt_q, clip_cnt_q;

  logic [COORD_W-1:0]   cur_x, cur_y;
  logic [FB_ADDR_W-1:0] cur_addr;
  logic                 cur_inb;
  logic [NPTS-2:0]      match;
  logic                 in_xfc, busy, dup, clip_skip, dup_skip, do_write, wr_done, advance;

  assign cur_x = x_q[idx_q];
  assign cur_y = y_q[idx_q];

  pixel_addr_calc #(.H_RES(H_RES), .V_RES(V_RES)) u_addr (
    .x_i         (cur_x),
    .y_i         (cur_y),
    .addr_o      (cur_addr),
    .in_bounds_o (cur_inb)
  );

  // A point repeats if it matches any earlier lane; lane 7 is never "earlier"
  for (genvar j = 0; j < NPTS - 1; j++) begin : g_dup
    assign match[j] = (IDX_W'(j) < idx_q) && (x_q[j] == cur_x) && (y_q[j] == cur_y);
  end
  assign dup = |match;

  assign busy      = (state_q == ST_WRITE);
  assign clip_skip = busy & ~cur_inb;
  assign dup_skip  = busy & cur_inb & dup;
  assign do_write  = busy & cur_inb & ~dup;
  assign wr_done   = do_write & fb_rtr;
  assign advance   = clip_skip | dup_skip | wr_done;

  assign in_rtr = (state_q == ST_IDLE);
  assign in_xfc = in_rts & in_rtr;

  assign fb_wr_en   = do_write;
  assign fb_addr    = do_write ? cur_addr : '0;
  assign fb_data    = do_write ? color_q  : '0;
  assign pix_count  = pix_cnt_q;
  assign clip_count = clip_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      idx_q      <= '0;
      pix_cnt_q  <= '0;
      clip_cnt_q <= '0;
    end else begin
      if (wr_done)   pix_cnt_q  <= pix_cnt_q + 16'd1;
      if (clip_skip) clip_cnt_q <= clip_cnt_q + 16'd1;
      case (state_q)
        ST_IDLE: if (in_xfc) begin
          x_q     <= {draw_x_7, draw_x_6, draw_x_5, draw_x_4,
                      draw_x_3, draw_x_2, draw_x_1, draw_x_0};
          y_q     <= {draw_y_7, draw_y_6, draw_y_5, draw_y_4,
                      draw_y_3, draw_y_2, draw_y_1, draw_y_0};
          color_q <= color;
          idx_q   <= '0;
          state_q <= ST_WRITE;
        end
        ST_WRITE: if (advance) begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NPTS - 1)) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_octant_pixel_writer.sv
// Directed bench for octant_pixel_writer with hand-computed expectations.
module tb_octant_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_;
  logic        in_rts;
  logic        in_rtr;
  logic [9:0]  gx [8];
  logic [9:0]  gy [8];
  logic [11:0] col;
  logic        fb_wr_en;
  logic        fb_rtr;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic [15:0] pix_count, clip_count;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int en_cnt = 0;
  logic [18:0] wa[$];
  logic [11:0] wd[$];

  always #5 clk = ~clk;

  octant_pixel_writer dut (
    .clk(clk), .rst_(rst_), .in_rts(in_rts), .in_rtr(in_rtr),
    .draw_x_0(gx[0]), .draw_x_1(gx[1]), .draw_x_2(gx[2]), .draw_x_3(gx[3]),
    .draw_x_4(gx[4]), .draw_x_5(gx[5]), .draw_x_6(gx[6]), .draw_x_7(gx[7]),
    .draw_y_0(gy[0]), .draw_y_1(gy[1]), .draw_y_2(gy[2]), .draw_y_3(gy[3]),
    .draw_y_4(gy[4]), .draw_y_5(gy[5]), .draw_y_6(gy[6]), .draw_y_7(gy[7]),
    .color(col), .fb_wr_en(fb_wr_en), .fb_rtr(fb_rtr), .fb_addr(fb_addr),
    .fb_data(fb_data), .pix_count(pix_count), .clip_count(clip_count)
  );

  // Inputs move at posedge+2, so the negedge sees what the next posedge will see
  always @(negedge clk) begin
    if (!rst_ && fb_wr_en) en_cnt++;
    if (!rst_ && fb_wr_en && fb_rtr) begin
      wa.push_back(fb_addr);
      wd.push_back(fb_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input bit keep);
    int n = 0;
    in_rts = 1'b1;
    while (!in_rtr && n < 50) begin tick(); n++; end
    if (!in_rtr) chk("accept_timeout", 32'(in_rtr), 1);
    tick();
    if (!keep) in_rts = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!in_rtr && n < 50) begin tick(); n++; end
    chk("idle_reached", 32'(in_rtr), 1);
  endtask

  initial begin
    int base, n, p0, en0;
    rst_ = 1'b1; in_rts = 1'b0; fb_rtr = 1'b1; col = '0;
    for (int i = 0; i < 8; i++) begin gx[i] = '0; gy[i] = '0; end
    tick(); tick();
    chk("rst_in_rtr", 32'(in_rtr), 1);
    chk("rst_wr_en", 32'(fb_wr_en), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_pix", 32'(pix_count), 0);
    chk("rst_clip", 32'(clip_count), 0);
    rst_ = 1'b0;
    tick();

    // All eight points identical: only the first one is written
    for (int i = 0; i < 8; i++) begin gx[i] = 10'd100; gy[i] = 10'd50; end
    col = 12'hF00; base = wa.size();
    send(0);
    chk("dup_first_wr_en", 32'(fb_wr_en), 1);
    chk("dup_rtr_busy", 32'(in_rtr), 0);
    wait_idle(n);
    chk("dup_nwrites", wa.size() - base, 1);
    chk("dup_addr", 32'(wa[base]), 32100);
    chk("dup_data", 32'(wd[base]), 32'h0F00);
    chk("dup_pix", 32'(pix_count), 1);
    chk("dup_clip", 32'(clip_count), 0);

    // Eight distinct in-bounds points including the far corner
    gx[0] = 0;   gy[0] = 0;   gx[1] = 1;   gy[1] = 0;
    gx[2] = 0;   gy[2] = 1;   gx[3] = 639; gy[3] = 479;
    gx[4] = 10;  gy[4] = 20;  gx[5] = 639; gy[5] = 0;
    gx[6] = 0;   gy[6] = 479; gx[7] = 320; gy[7] = 240;
    col = 12'h0F0; base = wa.size();
    send(0);
    wait_idle(n);
    // accept edge + 8 point edges + DONE edge: idle again 9 edges after accept
    chk("full_group_time", n, 9);
    chk("full_nwrites", wa.size() - base, 8);
    chk("full_addr0", 32'(wa[base]), 0);
    chk("full_addr2", 32'(wa[base+2]), 640);
    chk("full_corner", 32'(wa[base+3]), 307199);
    chk("full_addr4", 32'(wa[base+4]), 12810);
    chk("full_addr7", 32'(wa[base+7]), 153920);
    chk("full_data", 32'(wd[base+7]), 32'h00F0);
    chk("full_pix", 32'(pix_count), 9);

    // Two clipped points: x=1023 and y=480
    for (int i = 0; i < 8; i++) begin gx[i] = 10'(5 + i); gy[i] = 10'd5; end
    gx[3] = 10'd1023; gy[5] = 10'd480;
    col = 12'h00F; base = wa.size();
    send(0);
    wait_idle(n);
    chk("clip_nwrites", wa.size() - base, 6);
    chk("clip_count", 32'(clip_count), 2);
    chk("clip_addr0", 32'(wa[base]), 3205);
    chk("clip_addr3", 32'(wa[base+3]), 3209);
    chk("clip_addr5", 32'(wa[base+5]), 3212);
    chk("clip_pix", 32'(pix_count), 15);

    // Backpressure: hold fb_rtr low for three edges on the first write
    for (int i = 0; i < 8; i++) begin gx[i] = 10'd2; gy[i] = 10'd3; end
    col = 12'h5A5; fb_rtr = 1'b0; base = wa.size();
    send(0);
    for (int k = 0; k < 4; k++) begin
      chk("stall_wr_en", 32'(fb_wr_en), 1);
      chk("stall_addr", 32'(fb_addr), 1922);
      chk("stall_data", 32'(fb_data), 32'h05A5);
      if (k < 3) tick();
    end
    fb_rtr = 1'b1; p0 = 32'(pix_count);
    chk("stall_pix_held", p0, 15);
    tick();
    chk("stall_pix_done", 32'(pix_count), 16);
    chk("stall_then_skip", 32'(fb_wr_en), 0);
    wait_idle(n);
    chk("stall_nwrites", wa.size() - base, 1);

    // Reset while point 4 is being written
    for (int i = 0; i < 8; i++) begin gx[i] = 10'(i * 10); gy[i] = 10'd1; end
    col = 12'h123; base = wa.size();
    send(0);
    tick(); tick(); tick(); tick();
    chk("rstmid_wr_en", 32'(fb_wr_en), 1);
    chk("rstmid_prior", wa.size() - base, 4);
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    en0 = en_cnt;
    chk("rstmid_in_rtr", 32'(in_rtr), 1);
    chk("rstmid_wr_en0", 32'(fb_wr_en), 0);
    chk("rstmid_pix", 32'(pix_count), 0);
    chk("rstmid_clip", 32'(clip_count), 0);
    tick(); tick(); tick();
    chk("rstmid_no_writes", en_cnt - en0, 0);

    // in_rts held high across two groups; inputs wiggle during the first
    for (int i = 0; i < 8; i++) begin gx[i] = 10'd1; gy[i] = 10'd1; end
    col = 12'h0AA; base = wa.size();
    send(1);
    for (int i = 0; i < 8; i++) begin gx[i] = 10'd3; gy[i] = 10'd3; end
    col = 12'h0CC;
    for (int k = 0; k < 9; k++) begin
      chk("hold_rtr_busy", 32'(in_rtr), 0);
      if (k < 8) tick();
    end
    for (int i = 0; i < 8; i++) begin gx[i] = 10'd4; gy[i] = 10'd4; end
    col = 12'h0BB;
    tick();
    chk("hold_rtr_idle", 32'(in_rtr), 1);
    tick();
    chk("hold_rtr_second", 32'(in_rtr), 0);
    in_rts = 1'b0;
    wait_idle(n);
    chk("hold_nwrites", wa.size() - base, 2);
    chk("hold_addr_a", 32'(wa[base]), 641);
    chk("hold_data_a", 32'(wd[base]), 32'h00AA);
    chk("hold_addr_b", 32'(wa[base+1]), 2564);
    chk("hold_data_b", 32'(wd[base+1]), 32'h00BB);
    chk("hold_pix", 32'(pix_count), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
